// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: address/instruction widths, constants, IF states.
// Used by inst_fetch and, when ICACHE_EN is defined, by icache.
package inst_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [AddrLen-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_t;

    function automatic logic is_aligned(input logic [1:0] lo);
        return lo == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache (built only with ICACHE_EN).
// Combinational read, synchronous write; misaligned addresses never hit or fill.
`ifdef ICACHE_EN
module icache
    import inst_fetch_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AddrLen-1:0] raddr,
    output logic               hit,
    output logic [InstLen-1:0] rdata,
    input  logic               we,
    input  logic [AddrLen-1:0] waddr,
    input  logic [InstLen-1:0] wdata
);

    localparam int IdxW = $clog2(LINES);
    localparam int TagW = AddrLen - IdxW - 2;

    logic [LINES-1:0]   valid_q;
    logic [TagW-1:0]    tag_q  [LINES];
    logic [InstLen-1:0] data_q [LINES];

    logic [IdxW-1:0] ridx, widx;
    logic [TagW-1:0] rtag, wtag;
    logic            wen;

    assign ridx = raddr[IdxW+1:2];
    assign rtag = raddr[AddrLen-1:IdxW+2];
    assign widx = waddr[IdxW+1:2];
    assign wtag = waddr[AddrLen-1:IdxW+2];
    assign wen  = we && is_aligned(waddr[1:0]);

    assign hit   = valid_q[ridx] && (tag_q[ridx] == rtag)
                   && is_aligned(raddr[1:0]);
    assign rdata = data_q[ridx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wen) begin
            valid_q[widx] <= True;
        end
    end

    // Tag and data need no reset: valid bits gate every hit.
    always_ff @(posedge clk) begin
        if (wen) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

endmodule
`endif

// File: rtl/inst_fetch.sv
// IF stage: builds each instruction from four little-endian byte reads, holds it for decode.
// Define ICACHE_EN to add a direct-mapped single-cycle-hit instruction cache.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [AddrLen-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                 ICACHE_LINES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               id_stall,
    input  logic               jump_or_not,
    input  logic [AddrLen-1:0] jump_addr,
    output logic               mem_req,
    output logic [AddrLen-1:0] mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [7:0]         mem_rdata,
    output logic [AddrLen-1:0] pc_o,
    output logic [InstLen-1:0] inst_o,
    output logic               if_id_rdy
);

    if_state_t state_q, state_d;

    logic [AddrLen-1:0] pc_q;
    logic [2:0]         issue_cnt;
    logic [2:0]         recv_cnt;
    logic [InstLen-1:0] buf_q;
    logic               drop_q;
    logic               gnt_q;

    logic               fetching;
    logic               idle;
    logic               take;
    logic               done;
    logic               hit;
    logic               load;
    logic               release_hold;
    logic               jump;
    logic               grant;
    logic [InstLen-1:0] fetched_word;
    logic [InstLen-1:0] load_word;
    logic               cache_hit;
    logic [InstLen-1:0] cache_rdata;

    assign fetching = (state_q == IF_FETCH);
    assign idle     = fetching && (issue_cnt == 3'd0) && (recv_cnt == 3'd0);
    assign jump     = rdy && jump_or_not;

    // Byte capture ignores rdy so a returning byte is never lost.
    assign take = mem_rvalid && !drop_q && fetching && (recv_cnt != 3'd4);

    assign done = rdy && fetching
                  && ((recv_cnt == 3'd4) || ((recv_cnt == 3'd3) && take));

    assign hit          = idle && cache_hit;
    assign load         = (done || (rdy && hit)) && !jump_or_not;
    assign release_hold = rdy && !jump_or_not
                          && (state_q == IF_HOLD) && !id_stall;

    assign fetched_word = recv_cnt[2] ? buf_q : {mem_rdata, buf_q[23:0]};
    assign load_word    = hit ? cache_rdata : fetched_word;

    assign mem_req  = !rst && rdy && !jump_or_not && fetching
                      && !issue_cnt[2] && !hit;
    assign mem_addr = mem_req ? (pc_q + {29'd0, issue_cnt}) : ZERO_WORD;
    assign grant    = mem_req && mem_gnt;

`ifdef ICACHE_EN
    logic cache_we;

    assign cache_we = done && !jump_or_not;

    icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk   (clk),
        .rst   (rst),
        .raddr (pc_q),
        .hit   (cache_hit),
        .rdata (cache_rdata),
        .we    (cache_we),
        .waddr (pc_q),
        .wdata (fetched_word)
    );
`else
    assign cache_hit   = False;
    assign cache_rdata = ZERO_WORD;
`endif

    ap_lines_pow2: assert property (@(posedge clk) disable iff (rst)
        (ICACHE_LINES >= 2) && ((ICACHE_LINES & (ICACHE_LINES - 1)) == 0));

    always_comb begin
        state_d = state_q;
        if (!rdy) begin
            state_d = state_q;
        end else if (jump_or_not) begin
            state_d = IF_FETCH;
        end else if (load) begin
            state_d = IF_HOLD;
        end else if (release_hold) begin
            state_d = IF_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant whose byte has not come back by the redirect must be discarded later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            buf_q     <= ZERO_WORD;
            drop_q    <= gnt_q && !mem_rvalid;
            gnt_q     <= False;
            pc_o      <= ZERO_WORD;
            inst_o    <= ZERO_WORD;
            if_id_rdy <= False;
        end else begin
            gnt_q <= grant;
            if (mem_rvalid && drop_q) begin
                drop_q <= False;
            end
            if (jump) begin
                pc_q      <= jump_addr;
                issue_cnt <= 3'd0;
                recv_cnt  <= 3'd0;
                if_id_rdy <= False;
                drop_q    <= gnt_q && !mem_rvalid;
            end else begin
                if (take) begin
                    buf_q[{recv_cnt[1:0], 3'b000} +: 8] <= mem_rdata;
                    recv_cnt <= recv_cnt + 3'd1;
                end
                if (grant) begin
                    issue_cnt <= issue_cnt + 3'd1;
                end
                if (load) begin
                    pc_o      <= pc_q;
                    inst_o    <= load_word;
                    if_id_rdy <= True;
                    pc_q      <= pc_q + 32'd4;
                end else if (release_hold) begin
                    if_id_rdy <= False;
                    issue_cnt <= 3'd0;
                    recv_cnt  <= 3'd0;
                end
            end
        end
    end

endmodule
